// File: rtl/rf_access_ctrl.sv
// Register-file access controller: round-robin share of the RF write port and a dump sequencer on read port 1.
// Build option RF_ACCESS_STATS_EN adds saturating per-requester transfer counters (wr_cnt0/wr_cnt1).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | rf_ra follows cpu_ra, write requests may be accepted
// SCAN  | rf_ra walks 0..NREG-1 for the dump, write readys held low
module rf_access_ctrl #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic [AW-1:0] cpu_ra,
    output logic          cpu_stall,
    input  logic          dump_start,
    output logic          dump_busy,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_rd
`ifdef RF_ACCESS_STATS_EN
    ,
    output logic [15:0]   wr_cnt0,
    output logic [15:0]   wr_cnt1
`endif
);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          last_grant;   // 1: requester 1 won the last transfer
    logic          in_idle;
    logic          grant0, grant1;
    logic          xfer0, xfer1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign in_idle    = (state_q == S_IDLE);
    assign grant0     = req0_valid & (~req1_valid | last_grant);
    assign grant1     = req1_valid & (~req0_valid | ~last_grant);
    assign req0_ready = grant0 & ~freeze & in_idle;
    assign req1_ready = grant1 & ~freeze & in_idle;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign cpu_stall  = ~in_idle;
    assign dump_busy  = ~in_idle;
    assign rf_ra      = in_idle ? cpu_ra : idx_q;

    // Address 0 is hardwired in the RF: the handshake completes but no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
        end else begin
            rf_we <= (xfer0 && (req0_addr != '0)) || (xfer1 && (req1_addr != '0));
            if (xfer0) begin
                rf_wa      <= req0_addr;
                rf_wd      <= req0_data;
                last_grant <= 1'b0;
            end else if (xfer1) begin
                rf_wa      <= req1_addr;
                rf_wd      <= req1_data;
                last_grant <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            dump_valid <= (state_q == S_SCAN);
            if (state_q == S_SCAN) begin
                dump_idx  <= idx_q;
                dump_data <= rf_rd;
            end
        end
    end

`ifdef RF_ACCESS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt0 <= '0;
            wr_cnt1 <= '0;
        end else begin
            if (xfer0 && (wr_cnt0 != 16'hFFFF)) wr_cnt0 <= wr_cnt0 + 16'd1;
            if (xfer1 && (wr_cnt1 != 16'hFFFF)) wr_cnt1 <= wr_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl: vector table, directed dump sequences, randomized traffic vs a model.
// Build with RF_ACCESS_STATS_EN defined to also check the transfer counters.
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr, cpu_ra, dump_idx, rf_wa, rf_ra;
    logic [31:0] req0_data, req1_data, dump_data, rf_wd, rf_rd;
    logic        cpu_stall, dump_start, dump_busy, dump_valid, rf_we;
`ifdef RF_ACCESS_STATS_EN
    logic [15:0] wr_cnt0, wr_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_access_ctrl #(.AW(5), .DW(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .cpu_ra(cpu_ra), .cpu_stall(cpu_stall), .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd)
`ifdef RF_ACCESS_STATS_EN
        , .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
`endif
    );

    // Register file environment: reset contents rf[i] = i.
    logic [31:0] rf_mem [32];
    logic        rf_init;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'(i);
        end else if (rf_we) begin
            rf_mem[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd = rf_mem[rf_ra];

    typedef struct {
        logic        frz;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    vec_t        vt [14];
    wr_t         exp_wr [$];
    logic [31:0] shadow [32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        freeze = 0; req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        cpu_ra = 0; dump_start = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; rf_init = 1;
        step(); step();
        rst = 0; rf_init = 0;
    endtask

    initial begin
        int n0, n1, beats, stalls, cyc;
        logic h0, h1, e0, e1, mlast, found;
        wr_t w;

        vt[0]  = '{0, 1, 5'd1, 32'h0A00, 1, 5'd2, 32'h0B00, 1, 0, 1, 5'd1, 32'h0A00};
        vt[1]  = '{0, 1, 5'd1, 32'h0A01, 1, 5'd2, 32'h0B00, 0, 1, 1, 5'd2, 32'h0B00};
        vt[2]  = '{0, 1, 5'd1, 32'h0A01, 1, 5'd2, 32'h0B01, 1, 0, 1, 5'd1, 32'h0A01};
        vt[3]  = '{0, 1, 5'd1, 32'h0A02, 1, 5'd2, 32'h0B01, 0, 1, 1, 5'd2, 32'h0B01};
        vt[4]  = '{0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0};
        vt[5]  = '{0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd3, 32'hDEADBEEF};
        vt[6]  = '{0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0};
        vt[7]  = '{0, 0, 5'd0, 32'h0,    1, 5'd0, 32'h5,    0, 1, 0, 5'd0, 32'h0};
        vt[8]  = '{1, 1, 5'd7, 32'h77,   0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0};
        vt[9]  = '{1, 1, 5'd7, 32'h77,   0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0};
        vt[10] = '{1, 1, 5'd7, 32'h77,   0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0};
        vt[11] = '{0, 1, 5'd7, 32'h77,   0, 5'd0, 32'h0,    1, 0, 1, 5'd7, 32'h77};
        vt[12] = '{0, 0, 5'd0, 32'h0,    1, 5'd4, 32'h44,   0, 1, 1, 5'd4, 32'h44};
        vt[13] = '{1, 1, 5'd9, 32'h99,   1, 5'd8, 32'h88,   0, 0, 0, 5'd0, 32'h0};

        // ---- reset state ----
        do_reset();
        chk("rst rf_we", rf_we, 0);
        chk("rst dump_valid", dump_valid, 0);
        chk("rst dump_busy", dump_busy, 0);
        chk("rst cpu_stall", cpu_stall, 0);
        chk("rst ready0", req0_ready, 0);
        chk("rst rf_ra", rf_ra, cpu_ra);

        // ---- vector table ----
        n0 = 0; n1 = 0;
        for (int k = 0; k < 14; k++) begin
            freeze = vt[k].frz;
            req0_valid = vt[k].v0; req0_addr = vt[k].a0; req0_data = vt[k].d0;
            req1_valid = vt[k].v1; req1_addr = vt[k].a1; req1_data = vt[k].d1;
            #1;
            chk($sformatf("vec%0d ready0", k), req0_ready, vt[k].r0);
            chk($sformatf("vec%0d ready1", k), req1_ready, vt[k].r1);
            n0 += int'(vt[k].r0);
            n1 += int'(vt[k].r1);
            step();
            chk($sformatf("vec%0d rf_we", k), rf_we, vt[k].we);
            if (vt[k].we) begin
                chk($sformatf("vec%0d rf_wa", k), rf_wa, vt[k].wa);
                chk($sformatf("vec%0d rf_wd", k), rf_wd, vt[k].wd);
            end
        end
        idle_inputs();
        step();
        chk("post-table rf_we", rf_we, 0);
`ifdef RF_ACCESS_STATS_EN
        chk("table wr_cnt0", wr_cnt0, 64'(n0));
        chk("table wr_cnt1", wr_cnt1, 64'(n1));
`endif

        // ---- full dump, with a write accepted on the dump_start cycle ----
        do_reset();
        cpu_ra = 5'd3;
        req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hABCD;
        dump_start = 1;
        #1;
        chk("dump start-cycle ready0", req0_ready, 1);
        step();
        dump_start = 0;
        req0_addr = 5'd6; req0_data = 32'h6666;
        beats = 0; stalls = 0;
        for (int c = 0; c < 40; c++) begin
            if (dump_busy) begin
                stalls++;
                chk("dump ready0 low", req0_ready, 0);
                chk("dump stall", cpu_stall, 1);
            end
            if (dump_valid) begin
                chk("dump idx", dump_idx, 64'(beats));
                chk("dump data", dump_data, (beats == 5) ? 32'hABCD : 32'(beats));
                beats++;
            end
            if (!dump_busy) req0_valid = 0;
            dump_start = (c == 10);
            step();
        end
        dump_start = 0;
        chk("dump beats", 64'(beats), 32);
        chk("dump stall cycles", 64'(stalls), 32);
        chk("dump end rf_ra", rf_ra, cpu_ra);

        // ---- reset mid-dump ----
        do_reset();
        cpu_ra = 5'd9;
        dump_start = 1;
        step();
        dump_start = 0;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (dump_valid && dump_idx == 5'd10) found = 1;
            else step();
        end
        chk("reach beat 10", found, 1);
        rst = 1;
        step();
        chk("mid-rst busy", dump_busy, 0);
        chk("mid-rst valid", dump_valid, 0);
        chk("mid-rst stall", cpu_stall, 0);
        chk("mid-rst rf_ra", rf_ra, 5'd9);
        rst = 0;
        beats = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            beats += int'(dump_valid);
        end
        chk("post-rst beats", 64'(beats), 0);

        // ---- randomized traffic vs model ----
        do_reset();
        for (int i = 0; i < 32; i++) shadow[i] = 32'(i);
        mlast = 1; h0 = 0; h1 = 0; n0 = 0; n1 = 0;
        exp_wr.delete();
        for (cyc = 0; cyc < 400; cyc++) begin
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                chk("rnd rf_we", rf_we, 1);
                chk("rnd rf_wa", rf_wa, w.wa);
                chk("rnd rf_wd", rf_wd, w.wd);
            end else begin
                chk("rnd rf_we idle", rf_we, 0);
            end
            if (!h0) begin
                req0_valid = ($urandom_range(2) != 0);
                req0_addr = 5'($urandom); req0_data = $urandom;
            end
            if (!h1) begin
                req1_valid = ($urandom_range(2) != 0);
                req1_addr = 5'($urandom); req1_data = $urandom;
            end
            freeze = ($urandom_range(4) == 0);
            cpu_ra = 5'($urandom);
            #1;
            chk("rnd rf_ra", rf_ra, cpu_ra);
            e0 = !freeze && req0_valid && (!req1_valid || mlast);
            e1 = !freeze && req1_valid && (!req0_valid || !mlast);
            chk("rnd ready0", req0_ready, e0);
            chk("rnd ready1", req1_ready, e1);
            if (e0) begin
                mlast = 0; n0++;
                if (req0_addr != 0) begin
                    exp_wr.push_back('{req0_addr, req0_data});
                    shadow[req0_addr] = req0_data;
                end
            end else if (e1) begin
                mlast = 1; n1++;
                if (req1_addr != 0) begin
                    exp_wr.push_back('{req1_addr, req1_data});
                    shadow[req1_addr] = req1_data;
                end
            end
            h0 = req0_valid && !e0;
            h1 = req1_valid && !e1;
            step();
        end
        idle_inputs();
        if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("rnd last rf_we", rf_we, 1);
            chk("rnd last rf_wa", rf_wa, w.wa);
        end
`ifdef RF_ACCESS_STATS_EN
        step();
        chk("rnd wr_cnt0", wr_cnt0, 64'(n0));
        chk("rnd wr_cnt1", wr_cnt1, 64'(n1));
`endif
        step();
        dump_start = 1;
        step();
        dump_start = 0;
        beats = 0;
        for (int c = 0; c < 40; c++) begin
            if (dump_valid) begin
                chk($sformatf("rnd dump reg%0d", beats), dump_data, shadow[beats]);
                beats++;
            end
            step();
        end
        chk("rnd dump beats", 64'(beats), 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
Controller in front of the 32x32 register file. It shares the single RF write port between two requesters (req0 = core writeback, req1 = debug/loader) using round-robin arbitration with valid/ready handshakes. It also owns read port 1 for a dump sequencer that streams all registers out for board display. It drives the RF write enable, write address, write data and read address 1; it samples read data 1.

Parameters:
AW, 5, register address width
DW, 32, data width
NREG, 32, number of registers scanned by a dump (must be <= 2**AW)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  level; while high no write request is accepted (board switch hold)
req0_valid  input  1  requester 0 write request
req0_addr  input  AW  requester 0 destination register
req0_data  input  DW  requester 0 write data
req0_ready  output  1  requester 0 accept strobe
req1_valid  input  1  requester 1 write request
req1_addr  input  AW  requester 1 destination register
req1_data  input  DW  requester 1 write data
req1_ready  output  1  requester 1 accept strobe
cpu_ra  input  AW  core read address, normally forwarded to rf_ra
cpu_stall  output  1  high while the dump owns rf_ra
dump_start  input  1  single-cycle pulse; start a full dump
dump_busy  output  1  dump in progress
dump_valid  output  1  dump_idx/dump_data valid this cycle
dump_idx  output  AW  register index of dump_data
dump_data  output  DW  register contents
rf_we  output  1  to RF write enable
rf_wa  output  AW  to RF write address
rf_wd  output  DW  to RF write data
rf_ra  output  AW  to RF read address 1
rf_rd  input  DW  from RF read data 1 (combinational)

Behaviour:
- Reset values: all outputs 0; last_grant=1, so req0 wins first; FSM state IDLE.
- readyN is combinational: readyN = grantN & ~freeze & (state==IDLE). A transfer occurs when validN & readyN.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted on the last transfer wins.
  - last_grant updates only on a transfer.
  - Requesters must hold valid, addr and data stable until ready.
- Write port is registered, with 1-cycle latency. rf_we/rf_wa/rf_wd are asserted in the cycle after the transfer, for exactly one cycle. rf_we=0 in any cycle with no prior-cycle transfer.
- Write to address 0: the handshake completes and last_grant updates, but rf_we stays 0.
- freeze high: both ready=0. A write already registered still issues the next cycle.
- Dump FSM, IDLE -> SCAN -> IDLE:
  - IDLE: rf_ra=cpu_ra and cpu_stall=0. dump_start moves to SCAN with idx=0.
  - SCAN: rf_ra=idx, cpu_stall=1, dump_busy=1, write readys forced 0. idx increments each cycle. After idx=NREG-1 is issued, the next state is IDLE.
  - Data is registered: dump_valid, dump_idx and dump_data (=rf_rd) appear the cycle after each address. That gives exactly NREG consecutive dump_valid cycles, ending one cycle after SCAN exits.
- dump_start while busy: ignored.
- dump_start in the same cycle as a write transfer: the transfer completes (ready was high in IDLE) and its rf_we issues on the first SCAN cycle. The dump therefore reflects the RF with that write applied from index 1 onward; the register with index 0 is unaffected.
- Reset mid-dump: returns to IDLE next edge; dump_valid=0 and no further dump beats.

Optional Feature:
RF_ACCESS_STATS_EN
- Defined: adds outputs wr_cnt0 and wr_cnt1 (16 bits each). Each counts completed transfers from its requester, including address-0 writes. Counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0 addr=3 data=32'hDEADBEEF -> req0_ready same cycle; next cycle rf_we=1, rf_wa=3, rf_wd=32'hDEADBEEF; following cycle rf_we=0.
- req0 and req1 held valid for 4 transfers -> grants in order 0,1,0,1; rf_we high on 4 consecutive cycles.
- req1 addr=0 data=5 -> req1_ready=1, rf_we stays 0; with RF_ACCESS_STATS_EN defined, wr_cnt1 increments to 1.
- freeze=1 for 3 cycles with req0 valid -> req0_ready=0 and no rf_we; freeze drops -> accept next cycle.
- RF at reset values (rf[i]=i), pulse dump_start -> cpu_stall=1 for 32 cycles; 32 dump_valid beats with dump_idx=dump_data=0..31; a second dump_start mid-scan is ignored; write readys stay 0 throughout.
- rst asserted at dump beat 10 -> next cycle dump_busy=0, dump_valid=0, rf_ra=cpu_ra.
